// File: rtl/if_stage.sv
// Instruction-fetch stage: drives the imem handshake, tracks the fetch PC and owns the IF/ID
// register. A one-entry buffer parks a word that arrives while ID is stalled.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc4_o,
    output logic        valid_o
);

    typedef enum logic [1:0] {
        StFetch,
        StDrop,
        StBuf
    } state_t;

    state_t      state_q;
    logic [31:0] req_addr_q;
    logic [31:0] tgt_q;
    logic [31:0] buf_inst_q;
    logic [31:0] buf_pc_q;
    logic [31:0] inst_q;
    logic [31:0] pc_q;
    logic [31:0] pc4_q;
    logic        valid_q;

    logic [31:0] target;
    logic [31:0] req_addr_inc;

    assign target       = {redirect_pc_i[31:2], 2'b00};
    assign req_addr_inc = req_addr_q + 32'd4;

    assign imem_req  = (state_q != StBuf) && !rst;
    assign imem_addr = req_addr_q;
    assign inst_o    = inst_q;
    assign pc_o      = pc_q;
    assign pc4_o     = pc4_q;
    assign valid_o   = valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StFetch;
            req_addr_q <= RESET_PC;
            tgt_q      <= 32'd0;
            buf_inst_q <= NOP;
            buf_pc_q   <= 32'd0;
            inst_q     <= NOP;
            pc_q       <= 32'd0;
            pc4_q      <= 32'd4;
            valid_q    <= 1'b0;
        end else if (redirect_i) begin
            // Flush wins over a same-cycle stall; pc/pc4 are left as-is under the bubble.
            inst_q  <= NOP;
            valid_q <= 1'b0;
            unique case (state_q)
                StFetch: begin
                    if (imem_ready) begin
                        req_addr_q <= target;
                    end else begin
                        // Request in flight: keep the address stable, discard its response.
                        tgt_q   <= target;
                        state_q <= StDrop;
                    end
                end
                StDrop: begin
                    if (imem_ready) begin
                        req_addr_q <= target;
                        state_q    <= StFetch;
                    end else begin
                        tgt_q <= target;
                    end
                end
                StBuf: begin
                    req_addr_q <= target;
                    state_q    <= StFetch;
                end
                default: state_q <= StFetch;
            endcase
        end else if (stall_i) begin
            unique case (state_q)
                StFetch: begin
                    if (imem_ready) begin
                        buf_inst_q <= imem_rdata;
                        buf_pc_q   <= req_addr_q;
                        req_addr_q <= req_addr_inc;
                        state_q    <= StBuf;
                    end
                end
                StDrop: begin
                    if (imem_ready) begin
                        req_addr_q <= tgt_q;
                        state_q    <= StFetch;
                    end
                end
                StBuf: state_q <= StBuf;
                default: state_q <= StFetch;
            endcase
        end else begin
            unique case (state_q)
                StFetch: begin
                    if (imem_ready) begin
                        inst_q     <= imem_rdata;
                        pc_q       <= req_addr_q;
                        pc4_q      <= req_addr_inc;
                        valid_q    <= 1'b1;
                        req_addr_q <= req_addr_inc;
                    end else begin
                        inst_q  <= NOP;
                        valid_q <= 1'b0;
                    end
                end
                StDrop: begin
                    inst_q  <= NOP;
                    valid_q <= 1'b0;
                    if (imem_ready) begin
                        req_addr_q <= tgt_q;
                        state_q    <= StFetch;
                    end
                end
                StBuf: begin
                    // req_addr already points past the buffered word, so fetching resumes now.
                    inst_q  <= buf_inst_q;
                    pc_q    <= buf_pc_q;
                    pc4_q   <= buf_pc_q + 32'd4;
                    valid_q <= 1'b1;
                    state_q <= StFetch;
                end
                default: state_q <= StFetch;
            endcase
        end
    end

    a_addr_stable : assert property (@(posedge clk) disable iff (rst)
        (imem_req && !imem_ready) |=> $stable(imem_addr));

    a_pc4_link : assert property (@(posedge clk) disable iff (rst)
        pc4_q == pc_q + 32'd4);

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage against a behavioural imem with a programmable wait count.
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'd0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] inst_o;
    logic [31:0] pc_o;
    logic [31:0] pc4_o;
    logic        valid_o;

    int unsigned waits = 0;
    int unsigned cnt = 0;
    int n_vec = 0;
    int n_err = 0;

    if_stage #(
        .RESET_PC(32'h0000_0000),
        .NOP     (32'h0000_0013)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall_i      (stall_i),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .inst_o       (inst_o),
        .pc_o         (pc_o),
        .pc4_o        (pc4_o),
        .valid_o      (valid_o)
    );

    always #5 clk = ~clk;

    // Memory answers after `waits` cycles of a held request; withdrawal resets the count.
    assign imem_ready = imem_req && (cnt == waits);
    assign imem_rdata = imem_addr | 32'h0000_0013;

    always @(posedge clk) begin
        if (rst || !imem_req || imem_ready) cnt <= 0;
        else cnt <= cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        stall_i = 1'b0;
        redirect_i = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] a;
        waits = 0;
        rst = 1'b1;
        tick();
        tick();
        n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rst_req: got %b want 0", imem_req); end
        n_vec++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", valid_o); end
        n_vec++; if (inst_o !== NOP) begin n_err++; $display("FAIL rst_inst: got %h want %h", inst_o, NOP); end
        n_vec++; if (pc_o !== 32'd0) begin n_err++; $display("FAIL rst_pc: got %h want 0", pc_o); end
        n_vec++; if (pc4_o !== 32'd4) begin n_err++; $display("FAIL rst_pc4: got %h want 4", pc4_o); end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a = 32'(4 * i);
            n_vec++; if (imem_addr !== a) begin n_err++; $display("FAIL zw_addr[%0d]: got %h want %h", i, imem_addr, a); end
            if (i > 0) begin
                a = 32'(4 * (i - 1));
                n_vec++; if (pc_o !== a) begin n_err++; $display("FAIL zw_pc[%0d]: got %h want %h", i, pc_o, a); end
                n_vec++; if (pc4_o !== a + 4) begin n_err++; $display("FAIL zw_pc4[%0d]: got %h want %h", i, pc4_o, a + 4); end
                n_vec++; if (inst_o !== (a | 32'h13)) begin n_err++; $display("FAIL zw_inst[%0d]: got %h want %h", i, inst_o, a | 32'h13); end
                n_vec++; if (valid_o !== 1'b1) begin n_err++; $display("FAIL zw_valid[%0d]: got %b want 1", i, valid_o); end
            end
            tick();
        end
    endtask

    task automatic test_wait_states();
        logic [31:0] a;
        waits = 2;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            a = 32'(4 * k);
            for (int b = 0; b < 2; b++) begin
                tick();
                n_vec++; if (valid_o !== 1'b0 || inst_o !== NOP) begin n_err++; $display("FAIL ws_bubble[%0d.%0d]: got v=%b i=%h want v=0 i=%h", k, b, valid_o, inst_o, NOP); end
                n_vec++; if (imem_addr !== a) begin n_err++; $display("FAIL ws_addr[%0d.%0d]: got %h want %h", k, b, imem_addr, a); end
            end
            tick();
            n_vec++; if (valid_o !== 1'b1 || pc_o !== a) begin n_err++; $display("FAIL ws_inst[%0d]: got v=%b pc=%h want v=1 pc=%h", k, valid_o, pc_o, a); end
        end
        waits = 0;
    endtask

    task automatic test_stall();
        waits = 0;
        do_reset();
        tick();
        tick();
        tick();
        n_vec++; if (pc_o !== 32'h8) begin n_err++; $display("FAIL st_pre_pc: got %h want 8", pc_o); end
        stall_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_vec++; if (pc_o !== 32'h8 || valid_o !== 1'b1 || inst_o !== 32'h1B) begin n_err++; $display("FAIL st_hold[%0d]: got pc=%h v=%b i=%h want pc=8 v=1 i=1b", c, pc_o, valid_o, inst_o); end
            n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL st_req[%0d]: got %b want 0", c, imem_req); end
        end
        stall_i = 1'b0;
        tick();
        n_vec++; if (pc_o !== 32'hC || inst_o !== 32'h1F || valid_o !== 1'b1) begin n_err++; $display("FAIL st_rel_pc: got pc=%h i=%h v=%b want pc=c i=1f v=1", pc_o, inst_o, valid_o); end
        n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin n_err++; $display("FAIL st_rel_addr: got req=%b a=%h want req=1 a=10", imem_req, imem_addr); end
        tick();
        n_vec++; if (pc_o !== 32'h10 || inst_o !== 32'h13) begin n_err++; $display("FAIL st_next_pc: got pc=%h i=%h want pc=10 i=13", pc_o, inst_o); end
    endtask

    task automatic test_redirect_pending();
        waits = 0;
        do_reset();
        for (int c = 0; c < 8; c++) tick();
        n_vec++; if (imem_addr !== 32'h20 || pc_o !== 32'h1C) begin n_err++; $display("FAIL rp_pre: got a=%h pc=%h want a=20 pc=1c", imem_addr, pc_o); end
        waits = 2;
        redirect_i = 1'b1;
        redirect_pc_i = 32'h100;
        tick();
        redirect_i = 1'b0;
        for (int c = 0; c < 2; c++) begin
            n_vec++; if (imem_addr !== 32'h20 || imem_req !== 1'b1) begin n_err++; $display("FAIL rp_hold[%0d]: got a=%h req=%b want a=20 req=1", c, imem_addr, imem_req); end
            n_vec++; if (valid_o !== 1'b0 || inst_o !== NOP) begin n_err++; $display("FAIL rp_bubble[%0d]: got v=%b i=%h want v=0 i=%h", c, valid_o, inst_o, NOP); end
            tick();
        end
        n_vec++; if (imem_addr !== 32'h100 || valid_o !== 1'b0) begin n_err++; $display("FAIL rp_tgt: got a=%h v=%b want a=100 v=0", imem_addr, valid_o); end
        waits = 0;
        tick();
        n_vec++; if (pc_o !== 32'h100 || inst_o !== 32'h113 || valid_o !== 1'b1) begin n_err++; $display("FAIL rp_first: got pc=%h i=%h v=%b want pc=100 i=113 v=1", pc_o, inst_o, valid_o); end
    endtask

    task automatic test_redirect_and_stall();
        // Follows test_redirect_pending: a request at 0x104 is ready this cycle.
        redirect_i = 1'b1;
        stall_i = 1'b1;
        redirect_pc_i = 32'h40;
        tick();
        redirect_i = 1'b0;
        stall_i = 1'b0;
        n_vec++; if (valid_o !== 1'b0 || inst_o !== NOP) begin n_err++; $display("FAIL rs_bubble: got v=%b i=%h want v=0 i=%h", valid_o, inst_o, NOP); end
        n_vec++; if (imem_addr !== 32'h40) begin n_err++; $display("FAIL rs_addr: got %h want 40", imem_addr); end
        tick();
        n_vec++; if (pc_o !== 32'h40 || inst_o !== 32'h53 || valid_o !== 1'b1) begin n_err++; $display("FAIL rs_first: got pc=%h i=%h v=%b want pc=40 i=53 v=1", pc_o, inst_o, valid_o); end
    endtask

    task automatic test_redirect_buf();
        waits = 0;
        do_reset();
        tick();
        stall_i = 1'b1;
        tick();
        n_vec++; if (imem_req !== 1'b0 || pc_o !== 32'h0) begin n_err++; $display("FAIL rb_buf: got req=%b pc=%h want req=0 pc=0", imem_req, pc_o); end
        redirect_i = 1'b1;
        redirect_pc_i = 32'h80;
        tick();
        redirect_i = 1'b0;
        stall_i = 1'b0;
        n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h80 || valid_o !== 1'b0) begin n_err++; $display("FAIL rb_tgt: got req=%b a=%h v=%b want req=1 a=80 v=0", imem_req, imem_addr, valid_o); end
        tick();
        n_vec++; if (pc_o !== 32'h80 || inst_o !== 32'h93 || valid_o !== 1'b1) begin n_err++; $display("FAIL rb_first: got pc=%h i=%h v=%b want pc=80 i=93 v=1", pc_o, inst_o, valid_o); end
    endtask

    task automatic test_wrap();
        waits = 0;
        redirect_i = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFE;
        tick();
        redirect_i = 1'b0;
        n_vec++; if (imem_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wr_addr: got %h want fffffffc", imem_addr); end
        tick();
        n_vec++; if (pc_o !== 32'hFFFF_FFFC || pc4_o !== 32'h0) begin n_err++; $display("FAIL wr_pc: got pc=%h pc4=%h want pc=fffffffc pc4=0", pc_o, pc4_o); end
        n_vec++; if (inst_o !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL wr_inst: got %h want ffffffff", inst_o); end
        n_vec++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL wr_next: got %h want 0", imem_addr); end
        tick();
        n_vec++; if (pc_o !== 32'h0 || pc4_o !== 32'h4) begin n_err++; $display("FAIL wr_after: got pc=%h pc4=%h want pc=0 pc4=4", pc_o, pc4_o); end
    endtask

    initial begin
        test_reset();
        test_wait_states();
        test_stall();
        test_redirect_pending();
        test_redirect_and_stall();
        test_redirect_buf();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the five-stage RISC-V pipeline. Drives instruction-memory requests with a ready handshake, tracks the fetch PC, and owns the IF/ID pipeline register, whose `inst_o` feeds the ID-stage decoder (opcode, funct3 and funct7 fields). Accepts stall requests from the hazard unit and PC redirects (taken branch, jal, jalr) resolved in EX. Keeps a one-entry buffer so that no fetched word is lost or duplicated under stall.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `NOP`, default 32'h0000_0013 (`addi x0,x0,0`): bubble instruction placed in IF/ID.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `stall_i`  in  1  hazard unit: hold IF/ID (load-use).
- `redirect_i`  in  1  EX: flush IF/ID, fetch from `redirect_pc_i`.
- `redirect_pc_i`  in  32  redirect target; bits [1:0] are ignored and forced to 0.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  fetch address; held stable while `imem_req` is high and `imem_ready` is low.
- `imem_ready`  in  1  `imem_rdata` is valid this cycle for the current request.
- `imem_rdata`  in  32  fetched word.
- `inst_o`  out  32  IF/ID instruction.
- `pc_o`  out  32  IF/ID PC.
- `pc4_o`  out  32  IF/ID PC+4 (jal/jalr link value).
- `valid_o`  out  1  IF/ID holds a real instruction.

## Operation
- Registers:
  - `req_addr`: drives `imem_addr`.
  - `tgt`: pending redirect target.
  - Buffer `buf_inst` / `buf_pc`.
  - FSM state.
  - IF/ID register.
- FSM states:
  - FETCH: request outstanding at `req_addr`.
  - DROP: the outstanding response belongs to the wrong path and will be discarded.
  - BUF: fetched word is parked in the buffer, no request.
- `imem_req` = (state != BUF) && !rst.
- Per-cycle priority: rst > redirect > stall > normal.
- Reset:
  - state=FETCH, `req_addr`=RESET_PC.
  - `valid_o`=0, `inst_o`=NOP, `pc_o`=0, `pc4_o`=4, buffer cleared.
  - `imem_req`=0 while `rst` is high.
- Redirect (any state; overrides a same-cycle stall):
  - IF/ID gets `valid_o`=0, `inst_o`=NOP.
  - The buffer is discarded.
  - FETCH with `imem_ready`: response dropped; next `req_addr`=target; stay FETCH.
  - FETCH without `imem_ready`: `tgt`=target; go DROP. The address is not changed mid-request.
  - DROP: `tgt` is overwritten by the newer target.
  - BUF: `req_addr`=target; go FETCH.
- Stall, no redirect:
  - IF/ID holds all fields.
  - FETCH with `imem_ready`: buffer gets (`rdata`, `req_addr`); `req_addr`+=4; go BUF.
  - BUF: stays BUF.
  - DROP with `imem_ready`: `req_addr`=`tgt`; go FETCH.
- Normal:
  - FETCH with `imem_ready`: IF/ID gets (`rdata`, `req_addr`, `req_addr`+4, valid=1); `req_addr`+=4.
  - FETCH without `imem_ready`: IF/ID bubble (`valid_o`=0, `inst_o`=NOP).
  - BUF: IF/ID gets the buffer contents with valid=1; go FETCH. The request at the already-advanced `req_addr` starts the same cycle.
  - DROP: IF/ID bubble. If `imem_ready`, `req_addr`=`tgt` and go FETCH.
- Arithmetic: all PC math is 32-bit modulo 2^32; 32'hFFFF_FFFC+4 = 0.
- Invariant: every address is delivered to IF/ID exactly once, in order, between redirects.

## Timing
- Zero-wait memory (`imem_ready` in the request cycle): the word requested in cycle N appears in IF/ID at cycle N+1, giving one instruction per cycle.
- With k wait cycles: k bubbles before the instruction.
- Redirect asserted in cycle N:
  - IF/ID is a bubble at N+1.
  - Target request is visible at N+1 from FETCH or BUF.
  - From DROP, the target request is visible the cycle after the outstanding `imem_ready`.
  - The first target instruction reaches IF/ID no earlier than N+2.
- Stall release (BUF): the buffered instruction is in IF/ID the cycle after `stall_i` falls.
- `rst` mid-request: the outstanding response is ignored. The memory model must accept request withdrawal on reset.

## Test plan
- Reset with `RESET_PC`=0 and zero-wait memory returning addr|0x13: after `rst` falls, `imem_addr` = 0, 4, 8 on successive cycles; IF/ID `pc_o` = 0, 4, 8 one cycle later; `pc4_o` = 4, 8, 12; `valid_o`=1.
- 2-wait-state memory: each instruction is preceded by 2 bubbles (`inst_o`=0x13, `valid_o`=0); no address is repeated or skipped.
- `stall_i` held 3 cycles while `pc_o`=0x8:
  - IF/ID holds 0x8.
  - Word 0xC is buffered and `imem_req`=0.
  - On release, `pc_o`=0xC next cycle, then 0x10.
- `redirect_i` with target 0x100 while the request at 0x20 is waiting (ready arrives 2 cycles later):
  - `imem_addr` stays 0x20 until ready.
  - The 0x20 word is never in IF/ID.
  - The next request is 0x100; `pc_o`=0x100 follows.
- `redirect_i` and `stall_i` in the same cycle, target 0x40: the flush wins; IF/ID is a bubble and the next fetch is 0x40.
- Wrap-around: redirect target 0xFFFF_FFFE fetches 0xFFFF_FFFC; `pc4_o`=0; the next fetch address is 0x0.
